// File: rtl/feature_wr_dma_pkg.sv
`default_nettype none
// ---- feature_wr_dma_pkg : shared encodings for the feature write DMA (rev 1.0) ----
package feature_wr_dma_pkg;

  localparam int ADDR_W = 32;

  // Per-beat ctrl field: bit1 marks the first beat of a burst, bit0 the last.
  localparam logic [1:0] CTRL_FIRST  = 2'b10;
  localparam logic [1:0] CTRL_MID    = 2'b00;
  localparam logic [1:0] CTRL_LAST   = 2'b01;
  localparam logic [1:0] CTRL_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Request payload is {ctrl, len, addr, data}, MSB first.
  function automatic int pd_addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int pd_len_lsb(input int dw);
    return dw + ADDR_W;
  endfunction

  function automatic int pd_ctrl_lsb(input int dw, input int len_w);
    return dw + ADDR_W + len_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/feature_wr_credit.sv
`default_nettype none
// ---- feature_wr_credit : saturating outstanding-burst counter (rev 1.0) ----
module feature_wr_credit #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic credit_ok,
  output logic drained_nxt
);

  localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  // A burst end and a completion in the same cycle cancel; a stray
  // completion at zero (e.g. after a mid-job reset) is dropped.
  always_comb begin
    count_nxt = count;
    if (inc && !dec && count != CNT_MAX) begin
      count_nxt = count + CNT_ONE;
    end else if (dec && !inc && count != '0) begin
      count_nxt = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  assign credit_ok   = (count < CNT_MAX);
  assign drained_nxt = (count_nxt == '0);

endmodule
`default_nettype wire

// File: rtl/feature_wr_dma.sv
`default_nettype none
// ---- feature_wr_dma : bursts a feature-word stream onto one memory write port,
//      gated by outstanding-burst credit, one done pulse per job (rev 1.0) ----
module feature_wr_dma
  import feature_wr_dma_pkg::*;
#(
  parameter int DATA_WIDTH      = 256,
  parameter int LEN_W           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [31:0]                         cfg_base_addr,
  input  logic [31:0]                         cfg_total_words,
  input  logic [LEN_W:0]                      cfg_burst_words,
  output logic                                busy,
  output logic                                done,
  input  logic                                in_vld,
  output logic                                in_rdy,
  input  logic [DATA_WIDTH-1:0]               in_pd,
  output logic                                wr_req_vld,
  input  logic                                wr_req_rdy,
  output logic [2+LEN_W+ADDR_W+DATA_WIDTH-1:0] wr_req_pd,
  input  logic                                wr_rsp_complete
);

  localparam int             PD_ADDR_LSB = pd_addr_lsb(DATA_WIDTH);
  localparam int             PD_LEN_LSB  = pd_len_lsb(DATA_WIDTH);
  localparam int             PD_CTRL_LSB = pd_ctrl_lsb(DATA_WIDTH, LEN_W);
  localparam logic [31:0]    BEAT_BYTES  = 32'(DATA_WIDTH / 8);
  localparam logic [LEN_W:0] MAX_BEATS   = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0] ONE_BEAT    = (LEN_W+1)'(1);

  state_t          state, state_nxt;
  logic [31:0]     words_left;
  logic [31:0]     addr;
  logic [LEN_W:0]  eff_burst;
  logic [LEN_W:0]  burst_beats;
  logic [LEN_W:0]  beat_cnt;
  logic [LEN_W:0]  cur_beats;
  logic [LEN_W-1:0] len;
  logic [1:0]      ctrl;
  logic            first_beat, last_beat, en, xfer, burst_end;
  logic            credit_ok, drained_nxt;

  // Burst size is decided at the first beat and held for the rest of the burst.
  assign first_beat = (beat_cnt == '0);
  assign cur_beats  = !first_beat ? burst_beats :
                      (words_left < 32'(eff_burst)) ? words_left[LEN_W:0] : eff_burst;
  assign last_beat  = (beat_cnt == cur_beats - ONE_BEAT);
  assign len        = LEN_W'(cur_beats - ONE_BEAT);

  assign en         = (state == ST_SEND) && (!first_beat || credit_ok);
  assign in_rdy     = wr_req_rdy && en;
  assign wr_req_vld = in_vld && en;
  assign xfer       = in_vld && in_rdy;
  assign burst_end  = xfer && last_beat;
  assign busy       = (state != ST_IDLE);

  always_comb begin
    ctrl = CTRL_MID;
    if (first_beat && last_beat) begin
      ctrl = CTRL_SINGLE;
    end else if (first_beat) begin
      ctrl = CTRL_FIRST;
    end else if (last_beat) begin
      ctrl = CTRL_LAST;
    end
  end

  always_comb begin
    wr_req_pd = '0;
    if (en) begin
      wr_req_pd[PD_CTRL_LSB +: 2]      = ctrl;
      wr_req_pd[PD_LEN_LSB +: LEN_W]   = len;
      wr_req_pd[PD_ADDR_LSB +: ADDR_W] = addr;
      wr_req_pd[DATA_WIDTH-1:0]        = in_pd;
    end
  end

  feature_wr_credit #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk         (clk),
    .rst         (rst),
    .inc         (burst_end),
    .dec         (wr_rsp_complete),
    .credit_ok   (credit_ok),
    .drained_nxt (drained_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start && cfg_total_words != '0) state_nxt = ST_SEND;
      ST_SEND:  if (burst_end && words_left == 32'd1) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drained_nxt) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_left  <= '0;
      addr        <= '0;
      eff_burst   <= '0;
      burst_beats <= '0;
      beat_cnt    <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE && start) begin
        words_left <= cfg_total_words;
        addr       <= cfg_base_addr;
        eff_burst  <= (cfg_burst_words == '0 || cfg_burst_words > MAX_BEATS) ?
                      MAX_BEATS : cfg_burst_words;
        beat_cnt   <= '0;
        done       <= (cfg_total_words == '0);
      end else if (state == ST_DRAIN) begin
        done <= drained_nxt;
      end else if (xfer) begin
        words_left <= words_left - 32'd1;
        if (first_beat) burst_beats <= cur_beats;
        if (last_beat) begin
          beat_cnt <= '0;
          addr     <= addr + 32'(cur_beats) * BEAT_BYTES;
        end else begin
          beat_cnt <= beat_cnt + ONE_BEAT;
        end
      end
    end
  end

endmodule
`default_nettype wire
